channel_burst_injector: RTL and testbench
=========================================

# channel_burst_injector

Parametrised, synthesizable error-injection channel for the error-correction test path. It sits between the encoder output and the decoder input. It flips bits of a DATA_WIDTH-bit stream using per-lane pseudo-random generators, in either independent (IID) or two-state Gilbert-Elliott burst mode. Flow is valid/ready with a one-stage registered output, and saturating bit-error and beat-error counters are provided for BER measurement.

## Interface
- DATA_WIDTH, 8: bits per beat, 1..32.
- CNT_WIDTH, 32: width of each error counter.
- SEED, 32'h1234_5678: base seed for all generators.
- P_GOOD_ERR, 655: per-bit error threshold in GOOD state (IID mode uses this), 17-bit, units 2^-16, range 0..65536.
- P_BAD_ERR, 32768: per-bit error threshold in BAD state.
- P_G2B, 66: GOOD→BAD transition threshold per accepted beat.
- P_B2G, 6554: BAD→GOOD transition threshold per accepted beat.

Ports (clock and reset first):
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- MODE  in  2  0 bypass, 1 IID, 2 Gilbert-Elliott, 3 force (invert all bits).
- CNT_CLR  in  1  synchronous clear of both counters.
- DATA_IN  in  DATA_WIDTH  input beat.
- DATA_IN_VALID  in  1  input beat valid.
- DATA_IN_READY  out  1  block can accept a beat.
- DATA_OUT  out  DATA_WIDTH  DATA_IN XOR error mask, registered.
- ERROR_MASK  out  DATA_WIDTH  mask applied to DATA_OUT.
- ERROR_VALID  out  1  DATA_OUT_VALID & |ERROR_MASK.
- DATA_OUT_VALID  out  1  output beat valid.
- DATA_OUT_READY  in  1  downstream accepts.
- CH_STATE  out  1  0 GOOD, 1 BAD.
- BIT_ERR_CNT  out  CNT_WIDTH  total flipped bits, saturating.
- BEAT_ERR_CNT  out  CNT_WIDTH  beats with ≥1 flipped bit, saturating.

## Operation
- Generators: DATA_WIDTH lane generators L[i] plus one state generator S, each a 32-bit xorshift (x^=x<<13; x^=x>>17; x^=x<<5).
  - Reset seeds: L[i] = SEED + i*32'h9E37_79B9 (mod 2^32); S = ~SEED. A zero seed is replaced by 32'h1.
- Accept = DATA_IN_VALID & DATA_IN_READY. All generators advance only on accept, so the error pattern is a function of beat index alone, independent of stalls.
- Random draw: r_i = L[i][15:0] and r_s = S[15:0], taken from the current value before advance. A bit errs when r < threshold; threshold 0 never errs, threshold 65536 always errs.
- Mask per mode:
  - bypass: 0.
  - IID: bit i = (r_i < P_GOOD_ERR).
  - GE: bit i = (r_i < (CH_STATE ? P_BAD_ERR : P_GOOD_ERR)).
  - force: all ones.
- Burst FSM with states GOOD and BAD, updated only on accept in MODE 2:
  - GOOD→BAD if r_s < P_G2B.
  - BAD→GOOD if r_s < P_B2G.
  - The mask for a beat uses the state before the update.
  - In other modes the state holds. Changing MODE does not reset state or generators.
- Counters update on accept:
  - BIT_ERR_CNT += popcount(mask).
  - BEAT_ERR_CNT += (mask != 0).
  - Both saturate at 2^CNT_WIDTH−1.
  - CNT_CLR has priority: counters go to 0 and the coincident beat is not counted.

## Timing
- Reset (asynchronous assert, synchronous release): DATA_OUT=0, ERROR_MASK=0, DATA_OUT_VALID=0, ERROR_VALID=0, CH_STATE=0, both counters=0, generators reseeded. DATA_IN_READY=1 once reset is released.
- DATA_IN_READY = !DATA_OUT_VALID | DATA_OUT_READY (combinational).
- Latency: a beat accepted at edge n appears on DATA_OUT / ERROR_MASK / DATA_OUT_VALID after edge n, together with its counter update. Full throughput is 1 beat/cycle.
- Stall: while DATA_OUT_VALID & !DATA_OUT_READY, all outputs hold, nothing is accepted, and generators, FSM and counters are frozen.
- Simultaneous output handshake and input accept: the register loads the new beat with no bubble.
- Output handshake with no input: DATA_OUT_VALID falls the next cycle.
- MODE is sampled on the accepting edge only.
- Reset mid-stream: the in-flight beat is discarded and the sequence restarts from the seeds.

## Test plan
- Bypass, DATA_WIDTH=8, stream 0x00..0xFF with DATA_OUT_READY=1 → DATA_OUT equals DATA_IN one cycle later, ERROR_MASK=0, counters stay 0, throughput 1/cycle.
- Force mode, input 0xA5 ×10 → DATA_OUT=0x5A, ERROR_VALID=1, BIT_ERR_CNT=80, BEAT_ERR_CNT=10.
- IID with P_GOOD_ERR=0 then 65536, 100 beats each → 0 errors, then BIT_ERR_CNT=800.
- GE with P_G2B=65536, P_B2G=0, P_GOOD_ERR=0, P_BAD_ERR=65536, 5 beats → beat 1 clean, beats 2–5 fully inverted, CH_STATE=1 after first accept, BEAT_ERR_CNT=4.
- IID with P_GOOD_ERR=6554, 50 beats, DATA_OUT_READY low for 5 cycles at beat 20 → outputs held and DATA_IN_READY=0 during the stall; the mask sequence is bit-identical to a no-stall reference run.
- CNT_WIDTH=4, force mode, 20 beats with CNT_CLR pulsed at beat 18 → BEAT_ERR_CNT saturates at 15, reads 0 after the clear, 2 after beat 20. Then assert RESET mid-stream → all outputs 0 and the first post-reset mask sequence matches the first run.

Source files
------------

// File: rtl/channel_burst_injector_if.sv
// Valid/ready stream bundle between encoder output, the error-injection channel and decoder input.
`timescale 1ns/1ps
interface channel_burst_injector_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] DATA_IN;
  logic                  DATA_IN_VALID;
  logic                  DATA_IN_READY;
  logic [DATA_WIDTH-1:0] DATA_OUT;
  logic [DATA_WIDTH-1:0] ERROR_MASK;
  logic                  ERROR_VALID;
  logic                  DATA_OUT_VALID;
  logic                  DATA_OUT_READY;

  // Channel side: consumes the input beat, produces the corrupted output beat
  modport slave (
    input  DATA_IN, DATA_IN_VALID, DATA_OUT_READY,
    output DATA_IN_READY, DATA_OUT, ERROR_MASK, ERROR_VALID, DATA_OUT_VALID
  );

  // Environment side: drives input beats and accepts output beats
  modport master (
    output DATA_IN, DATA_IN_VALID, DATA_OUT_READY,
    input  DATA_IN_READY, DATA_OUT, ERROR_MASK, ERROR_VALID, DATA_OUT_VALID
  );
endinterface

// File: rtl/channel_burst_injector.sv
// Bit-error injection channel: per-lane xorshift generators, IID or Gilbert-Elliott
// burst errors, one-stage registered valid/ready output and saturating BER counters.
`timescale 1ns/1ps
module channel_burst_injector #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 32,
  parameter logic [31:0] SEED       = 32'h1234_5678,
  parameter int unsigned P_GOOD_ERR = 655,
  parameter int unsigned P_BAD_ERR  = 32768,
  parameter int unsigned P_G2B      = 66,
  parameter int unsigned P_B2G      = 6554
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [1:0]            MODE,
  input  logic                  CNT_CLR,
  channel_burst_injector_if.slave bus,
  output logic                  CH_STATE,
  output logic [CNT_WIDTH-1:0]  BIT_ERR_CNT,
  output logic [CNT_WIDTH-1:0]  BEAT_ERR_CNT
);

  localparam logic [31:0]  C_GOLDEN   = 32'h9E37_79B9;
  localparam int unsigned  PC_W       = $clog2(DATA_WIDTH + 1);
  localparam int unsigned  SUM_W      = ((CNT_WIDTH > PC_W) ? CNT_WIDTH : PC_W) + 1;
  localparam logic [16:0]  C_THR_GOOD = 17'(P_GOOD_ERR);
  localparam logic [16:0]  C_THR_BAD  = 17'(P_BAD_ERR);
  localparam logic [16:0]  C_THR_G2B  = 17'(P_G2B);
  localparam logic [16:0]  C_THR_B2G  = 17'(P_B2G);
  localparam logic [SUM_W-1:0] C_CNT_MAX = SUM_W'({CNT_WIDTH{1'b1}});

  localparam logic [1:0] MODE_BYPASS = 2'd0;
  localparam logic [1:0] MODE_IID    = 2'd1;
  localparam logic [1:0] MODE_GE     = 2'd2;
  localparam logic [1:0] MODE_FORCE  = 2'd3;

  typedef enum logic {ST_GOOD = 1'b0, ST_BAD = 1'b1} state_t;

  function automatic logic [31:0] nz_seed(input logic [31:0] s);
    return (s == 32'd0) ? 32'd1 : s;
  endfunction

  function automatic logic [31:0] lane_seed(input int unsigned idx);
    return nz_seed(SEED + (idx * C_GOLDEN));
  endfunction

  function automatic logic [31:0] xs32(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  state_t                r_state;
  state_t                w_state_nxt;
  logic [31:0]           r_lane [DATA_WIDTH];
  logic [31:0]           r_sgen;
  logic [DATA_WIDTH-1:0] r_dout;
  logic [DATA_WIDTH-1:0] r_mask;
  logic                  r_dvalid;
  logic                  r_evalid;
  logic [CNT_WIDTH-1:0]  r_bit_cnt;
  logic [CNT_WIDTH-1:0]  r_beat_cnt;

  logic                  w_in_ready;
  logic                  w_accept;
  logic [16:0]           w_rs;
  logic [16:0]           w_thr;
  logic [DATA_WIDTH-1:0] w_hit;
  logic [DATA_WIDTH-1:0] w_mask;
  logic [PC_W-1:0]       w_popcnt;
  logic [SUM_W-1:0]      w_bit_sum;
  logic [SUM_W-1:0]      w_beat_sum;

  assign w_in_ready = !r_dvalid || bus.DATA_OUT_READY;
  assign w_accept   = bus.DATA_IN_VALID && w_in_ready;
  assign w_rs       = {1'b0, r_sgen[15:0]};

  // Burst channel state register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) r_state <= ST_GOOD;
    else        r_state <= w_state_nxt;
  end

  // State transitions are drawn once per accepted beat, GE mode only
  always_comb begin
    w_state_nxt = r_state;
    if (w_accept && (MODE == MODE_GE)) begin
      case (r_state)
        ST_GOOD: if (w_rs < C_THR_G2B) w_state_nxt = ST_BAD;
        ST_BAD:  if (w_rs < C_THR_B2G) w_state_nxt = ST_GOOD;
        default: w_state_nxt = ST_GOOD;
      endcase
    end
  end

  // Error mask uses the pre-update state and pre-advance generator values
  always_comb begin
    w_thr = ((MODE == MODE_GE) && (r_state == ST_BAD)) ? C_THR_BAD : C_THR_GOOD;
    w_hit = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      w_hit[i] = ({1'b0, r_lane[i][15:0]} < w_thr);
    end
    case (MODE)
      MODE_BYPASS: w_mask = '0;
      MODE_IID:    w_mask = w_hit;
      MODE_GE:     w_mask = w_hit;
      MODE_FORCE:  w_mask = '1;
      default:     w_mask = '0;
    endcase
    w_popcnt = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      w_popcnt = w_popcnt + PC_W'(w_mask[i]);
    end
  end

  // Generators step only on accept so the pattern depends on beat index alone
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int unsigned i = 0; i < DATA_WIDTH; i++) r_lane[i] <= lane_seed(i);
      r_sgen <= nz_seed(~SEED);
    end else if (w_accept) begin
      for (int unsigned i = 0; i < DATA_WIDTH; i++) r_lane[i] <= xs32(r_lane[i]);
      r_sgen <= xs32(r_sgen);
    end
  end

  // One-stage output register; reloads in the same cycle the old beat leaves
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_dout   <= '0;
      r_mask   <= '0;
      r_dvalid <= 1'b0;
      r_evalid <= 1'b0;
    end else if (w_accept) begin
      r_dout   <= bus.DATA_IN ^ w_mask;
      r_mask   <= w_mask;
      r_dvalid <= 1'b1;
      r_evalid <= |w_mask;
    end else if (bus.DATA_OUT_READY) begin
      r_dvalid <= 1'b0;
      r_evalid <= 1'b0;
    end
  end

  assign w_bit_sum  = SUM_W'(r_bit_cnt) + SUM_W'(w_popcnt);
  assign w_beat_sum = SUM_W'(r_beat_cnt) + SUM_W'(|w_mask);

  // Saturating error counters; clear wins over a coincident beat
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_bit_cnt  <= '0;
      r_beat_cnt <= '0;
    end else if (CNT_CLR) begin
      r_bit_cnt  <= '0;
      r_beat_cnt <= '0;
    end else if (w_accept) begin
      r_bit_cnt  <= (w_bit_sum  > C_CNT_MAX) ? '1 : CNT_WIDTH'(w_bit_sum);
      r_beat_cnt <= (w_beat_sum > C_CNT_MAX) ? '1 : CNT_WIDTH'(w_beat_sum);
    end
  end

  assign bus.DATA_IN_READY  = w_in_ready;
  assign bus.DATA_OUT       = r_dout;
  assign bus.ERROR_MASK     = r_mask;
  assign bus.ERROR_VALID    = r_evalid;
  assign bus.DATA_OUT_VALID = r_dvalid;
  assign CH_STATE           = r_state;
  assign BIT_ERR_CNT        = r_bit_cnt;
  assign BEAT_ERR_CNT       = r_beat_cnt;

endmodule

// File: tb/tb_channel_burst_injector.sv
// Self-checking bench: four channel configurations run in lockstep against a reference model and scoreboard.
`timescale 1ns/1ps
module tb_channel_burst_injector;

  localparam int unsigned W = 8;
  localparam logic [31:0] SEED = 32'h1234_5678;
  localparam logic [31:0] GOLD = 32'h9E37_79B9;
  // index 0: IID 10%, 1: deterministic GE, 2: always-err, 3: 4-bit counters
  localparam logic [3:0][31:0] PG   = {32'd655,   32'd65536, 32'd0,     32'd6554};
  localparam logic [3:0][31:0] PB   = {32'd32768, 32'd32768, 32'd65536, 32'd32768};
  localparam logic [3:0][31:0] PG2B = {32'd66,    32'd66,    32'd65536, 32'd66};
  localparam logic [3:0][31:0] PB2G = {32'd6554,  32'd6554,  32'd0,     32'd6554};
  localparam logic [3:0][31:0] CWS  = {32'd4,     32'd32,    32'd32,    32'd32};

  typedef logic [3:0][15:0] exp_t;   // per DUT: {data_out, mask}

  logic       CLK;
  logic       RESET;
  logic [1:0] MODE;
  logic       CNT_CLR;
  logic [7:0] din;
  logic       dvalid;
  logic       oready;

  logic [3:0][7:0]  o_dout, o_mask;
  logic [3:0]       o_dv, o_ev, o_rdy, o_ch;
  logic [3:0][31:0] o_bit, o_beat;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned CW = CWS[g];
    logic [CW-1:0] w_bit, w_beat;
    channel_burst_injector_if #(.DATA_WIDTH(W)) bus ();
    assign bus.DATA_IN        = din;
    assign bus.DATA_IN_VALID  = dvalid;
    assign bus.DATA_OUT_READY = oready;
    channel_burst_injector #(
      .DATA_WIDTH(W), .CNT_WIDTH(CW), .SEED(SEED),
      .P_GOOD_ERR(PG[g]), .P_BAD_ERR(PB[g]), .P_G2B(PG2B[g]), .P_B2G(PB2G[g])
    ) u_dut (
      .CLK(CLK), .RESET(RESET), .MODE(MODE), .CNT_CLR(CNT_CLR),
      .bus(bus.slave), .CH_STATE(o_ch[g]),
      .BIT_ERR_CNT(w_bit), .BEAT_ERR_CNT(w_beat)
    );
    assign o_dout[g] = bus.DATA_OUT;
    assign o_mask[g] = bus.ERROR_MASK;
    assign o_dv[g]   = bus.DATA_OUT_VALID;
    assign o_ev[g]   = bus.ERROR_VALID;
    assign o_rdy[g]  = bus.DATA_IN_READY;
    assign o_bit[g]  = 32'(w_bit);
    assign o_beat[g] = 32'(w_beat);
  end

  // Reference model state
  logic [31:0] m_lane [4][8];
  logic [31:0] m_sgen [4];
  logic        m_st   [4];
  logic [31:0] m_bit  [4];
  logic [31:0] m_beat [4];
  logic        m_ov;
  exp_t        sb_q [$];
  exp_t        m_last;
  logic [7:0]  first_run [10];

  int n_tests;
  int n_fail;

  function automatic logic [31:0] nz(input logic [31:0] s);
    return (s == 32'd0) ? 32'd1 : s;
  endfunction

  function automatic logic [31:0] xs(input logic [31:0] x);
    x ^= x << 13;
    x ^= x >> 17;
    x ^= x << 5;
    return x;
  endfunction

  function automatic logic [31:0] cnt_max(input int k);
    return (CWS[k] >= 32) ? 32'hFFFF_FFFF : ((32'd1 << CWS[k]) - 32'd1);
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 8; i++) m_lane[k][i] = nz(SEED + (32'(i) * GOLD));
      m_sgen[k] = nz(~SEED);
      m_st[k]   = 1'b0;
      m_bit[k]  = 32'd0;
      m_beat[k] = 32'd0;
    end
    m_ov = 1'b0;
    sb_q.delete();
  endtask

  task automatic model_accept(input logic [1:0] md, input logic [7:0] d, input logic clr, output exp_t e);
    for (int k = 0; k < 4; k++) begin
      logic [7:0]  mk;
      logic [31:0] thr, rs, mx;
      logic [32:0] s;
      thr = (md == 2'd2 && m_st[k]) ? PB[k] : PG[k];
      mk = 8'h00;
      for (int i = 0; i < 8; i++) if ((m_lane[k][i] & 32'hFFFF) < thr) mk[i] = 1'b1;
      if (md == 2'd0) mk = 8'h00;
      if (md == 2'd3) mk = 8'hFF;
      if (md == 2'd2) begin
        rs = m_sgen[k] & 32'hFFFF;
        if (!m_st[k]) m_st[k] = (rs < PG2B[k]);
        else          m_st[k] = !(rs < PB2G[k]);
      end
      for (int i = 0; i < 8; i++) m_lane[k][i] = xs(m_lane[k][i]);
      m_sgen[k] = xs(m_sgen[k]);
      mx = cnt_max(k);
      if (clr) begin
        m_bit[k]  = 32'd0;
        m_beat[k] = 32'd0;
      end else begin
        s = {1'b0, m_bit[k]} + 33'($countones(mk));
        m_bit[k] = (s > {1'b0, mx}) ? mx : s[31:0];
        s = {1'b0, m_beat[k]} + 33'(mk != 8'h00);
        m_beat[k] = (s > {1'b0, mx}) ? mx : s[31:0];
      end
      e[k] = {d ^ mk, mk};
    end
  endtask

  task automatic check_out();
    exp_t cur;
    cur = (sb_q.size() > 0) ? sb_q[0] : '0;
    for (int k = 0; k < 4; k++) begin
      chk("out_valid", k, 32'(o_dv[k]), 32'(m_ov));
      if (m_ov) begin
        chk("data_out", k, 32'(o_dout[k]), 32'(cur[k][15:8]));
        chk("err_mask", k, 32'(o_mask[k]), 32'(cur[k][7:0]));
      end
      chk("err_valid", k, 32'(o_ev[k]), 32'(m_ov && (cur[k][7:0] != 8'h00)));
      chk("ch_state", k, 32'(o_ch[k]), 32'(m_st[k]));
      chk("bit_cnt", k, o_bit[k], m_bit[k]);
      chk("beat_cnt", k, o_beat[k], m_beat[k]);
    end
  endtask

  task automatic check_reset();
    for (int k = 0; k < 4; k++) begin
      chk("rst_dout", k, 32'(o_dout[k]), 32'd0);
      chk("rst_mask", k, 32'(o_mask[k]), 32'd0);
      chk("rst_dvalid", k, 32'(o_dv[k]), 32'd0);
      chk("rst_evalid", k, 32'(o_ev[k]), 32'd0);
      chk("rst_state", k, 32'(o_ch[k]), 32'd0);
      chk("rst_bit", k, o_bit[k], 32'd0);
      chk("rst_beat", k, o_beat[k], 32'd0);
      chk("rst_ready", k, 32'(o_rdy[k]), 32'd1);
    end
  endtask

  // One clock: drive at negedge, predict, then sample at the following negedge
  task automatic step(input logic v, input logic [7:0] d, input logic r, input logic clr);
    exp_t e, junk;
    logic rdy, acc;
    dvalid = v; din = d; oready = r; CNT_CLR = clr;
    #1;
    rdy = !m_ov || r;
    for (int k = 0; k < 4; k++) chk("in_ready", k, 32'(o_rdy[k]), 32'(rdy));
    acc = v && rdy;
    if (m_ov && r) begin
      junk = sb_q.pop_front();
      m_ov = 1'b0;
    end
    if (acc) begin
      model_accept(MODE, d, clr, e);
      sb_q.push_back(e);
      m_ov   = 1'b1;
      m_last = e;
    end else if (clr) begin
      for (int k = 0; k < 4; k++) begin
        m_bit[k]  = 32'd0;
        m_beat[k] = 32'd0;
      end
    end
    @(posedge CLK);
    @(negedge CLK);
    check_out();
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    #1;
    model_reset();
    check_reset();
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    dvalid = 1'b0; din = 8'h00; oready = 1'b0; MODE = 2'd0; CNT_CLR = 1'b0;
    RESET = 1'b1;
    #1;
    RESET = 1'b0;
    #1;
    model_reset();
    check_reset();
    repeat (2) @(negedge CLK);
    RESET = 1'b1;

    // Bypass stream at full rate
    MODE = 2'd0;
    for (int j = 0; j < 256; j++) step(1'b1, 8'(j), 1'b1, 1'b0);

    // Force mode
    MODE = 2'd3;
    repeat (10) step(1'b1, 8'hA5, 1'b1, 1'b0);
    chk("force_dout", 0, 32'(o_dout[0]), 32'h5A);
    chk("force_evalid", 0, 32'(o_ev[0]), 32'd1);
    chk("force_bits", 0, o_bit[0], 32'd80);
    chk("force_beats", 0, o_beat[0], 32'd10);
    chk("force_bits_sat", 3, o_bit[3], 32'd15);

    // IID with never-err and always-err thresholds
    step(1'b0, 8'h00, 1'b1, 1'b1);
    MODE = 2'd1;
    repeat (100) step(1'b1, 8'($urandom), 1'b1, 1'b0);
    chk("iid_zero_bits", 1, o_bit[1], 32'd0);
    chk("iid_full_bits", 2, o_bit[2], 32'd800);
    chk("iid_full_beats", 2, o_beat[2], 32'd100);

    // Gilbert-Elliott: immediate GOOD->BAD, never back
    step(1'b0, 8'h00, 1'b1, 1'b1);
    MODE = 2'd2;
    for (int j = 0; j < 5; j++) begin
      step(1'b1, 8'h3C, 1'b1, 1'b0);
      chk("ge_mask", 1, 32'(o_mask[1]), (j == 0) ? 32'h00 : 32'hFF);
      chk("ge_state", 1, 32'(o_ch[1]), 32'd1);
    end
    chk("ge_beats", 1, o_beat[1], 32'd4);

    // IID with a 5-cycle downstream stall at beat 20
    MODE = 2'd1;
    for (int j = 0; j < 50; j++) begin
      if (j == 20) begin
        repeat (5) begin
          step(1'b1, 8'(j * 7 + 3), 1'b0, 1'b0);
          chk("stall_ready", 0, 32'(o_rdy[0]), 32'd0);
        end
      end
      step(1'b1, 8'(j * 7 + 3), 1'b1, 1'b0);
    end

    // Counter saturation and clear priority on 4-bit counters
    step(1'b0, 8'h00, 1'b1, 1'b1);
    MODE = 2'd3;
    for (int j = 1; j <= 20; j++) begin
      step(1'b1, 8'(j), 1'b1, (j == 18));
      if (j == 17) chk("sat_beats", 3, o_beat[3], 32'd15);
      if (j == 18) chk("clr_beats", 3, o_beat[3], 32'd0);
      if (j == 20) chk("post_clr_beats", 3, o_beat[3], 32'd2);
    end

    // Reference run from seeds, then mid-stream reset and replay
    do_reset();
    MODE = 2'd1;
    for (int j = 0; j < 10; j++) begin
      step(1'b1, 8'(j), 1'b1, 1'b0);
      first_run[j] = m_last[0][7:0];
    end
    repeat (5) step(1'b1, 8'h77, 1'b1, 1'b0);
    do_reset();
    MODE = 2'd1;
    for (int j = 0; j < 10; j++) begin
      step(1'b1, 8'(j), 1'b1, 1'b0);
      chk("rerun_mask", 0, 32'(o_mask[0]), 32'(first_run[j]));
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
